// File: rtl/time_set_pkg.sv
// Shared state encoding and time-range limits for the time-setting arbiter.
// Latency: none (declarations only). Backpressure: not applicable.
// Includes a small helper that range-checks a 24h time value.
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT12 = 2'b01,
    ST_GRANT24 = 2'b10,
    ST_COMMIT  = 2'b11
  } state_t;

  localparam logic [3:0] HOURS12_MAX = 4'd12;
  localparam logic [4:0] HOURS24_MAX = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;

  function automatic logic time24_valid(input logic [4:0] hours, input logic [5:0] minutes);
    return (hours <= HOURS24_MAX) && (minutes <= MINUTES_MAX);
  endfunction

endpackage

// File: rtl/hour12_to_24.sv
// Converts a 12h AM/PM time to 24h hours and flags out-of-range input.
// Latency: purely combinational. Backpressure: none.
module hour12_to_24
  import time_set_pkg::*;
(
  input  logic       is_pm,
  input  logic [3:0] hours12,
  input  logic [5:0] minutes,
  output logic [4:0] hours24,
  output logic       valid
);

  logic [4:0] hours_ext;

  assign hours_ext = {1'b0, hours12};
  assign valid     = (hours12 != 4'd0) && (hours12 <= HOURS12_MAX) && (minutes <= MINUTES_MAX);

  // 12 is the odd one out: 12 AM is midnight, 12 PM is noon.
  always_comb begin
    hours24 = hours_ext;
    if (hours12 == HOURS12_MAX) begin
      hours24 = is_pm ? 5'd12 : 5'd0;
    end else if (is_pm) begin
      hours24 = hours_ext + 5'd12;
    end
  end

endmodule

// File: rtl/time_set_arbiter.sv
// Round-robin owner arbiter between 12h and 24h setters loading a shared clock core.
// Latency: request->grant 1 cycle, prop->commit 1 cycle. Backpressure: grant held until prop/cancel.
// Optional macro TIMEOUT_EN revokes an idle grant after TIMEOUT_CYCLES cycles.
module time_set_arbiter
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req12,
  input  logic       req24,
  input  logic       prop12,
  input  logic       in12_isPM,
  input  logic [3:0] in12_hours,
  input  logic [5:0] in12_minutes,
  input  logic       prop24,
  input  logic [4:0] in24_hours,
  input  logic [5:0] in24_minutes,
  input  logic       cancel,
  output logic       grant12,
  output logic       grant24,
  output logic       commit,
  output logic [4:0] commit_hours,
  output logic [5:0] commit_minutes,
  output logic       err,
  output logic       busy,
  output logic [1:0] state
);

  state_t     state_q;
  logic       last_served_24;
  logic       pend_24;
  logic       timeout_hit;
  logic [4:0] cvt_hours;
  logic       cvt_valid;
  logic       own_prop;
  logic       own_ok;
  logic [4:0] own_hours;
  logic [5:0] own_minutes;

  hour12_to_24 u_cvt (
    .is_pm   (in12_isPM),
    .hours12 (in12_hours),
    .minutes (in12_minutes),
    .hours24 (cvt_hours),
    .valid   (cvt_valid)
  );

  // Only the current owner's propagate is looked at; the other side is ignored.
  always_comb begin
    own_prop    = 1'b0;
    own_ok      = 1'b0;
    own_hours   = in24_hours;
    own_minutes = in24_minutes;
    if (state_q == ST_GRANT12) begin
      own_prop    = prop12;
      own_ok      = cvt_valid;
      own_hours   = cvt_hours;
      own_minutes = in12_minutes;
    end else if (state_q == ST_GRANT24) begin
      own_prop    = prop24;
      own_ok      = time24_valid(in24_hours, in24_minutes);
    end
  end

`ifdef TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if ((state_q == ST_GRANT12 || state_q == ST_GRANT24) && !own_prop) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      last_served_24 <= 1'b1;
      pend_24        <= 1'b0;
      grant12        <= 1'b0;
      grant24        <= 1'b0;
      commit         <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
      commit_hours   <= '0;
      commit_minutes <= '0;
    end else begin
      commit <= 1'b0;
      err    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req12 && (!req24 || last_served_24)) begin
            state_q <= ST_GRANT12;
            grant12 <= 1'b1;
            busy    <= 1'b1;
          end else if (req24) begin
            state_q <= ST_GRANT24;
            grant24 <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_GRANT12, ST_GRANT24: begin
          // prop outranks both cancel and timeout in the same cycle.
          if (own_prop) begin
            grant12 <= 1'b0;
            grant24 <= 1'b0;
            if (own_ok) begin
              state_q        <= ST_COMMIT;
              commit         <= 1'b1;
              commit_hours   <= own_hours;
              commit_minutes <= own_minutes;
              pend_24        <= (state_q == ST_GRANT24);
            end else begin
              state_q <= ST_IDLE;
              err     <= 1'b1;
              busy    <= 1'b0;
            end
          end else if (cancel || timeout_hit) begin
            state_q <= ST_IDLE;
            grant12 <= 1'b0;
            grant24 <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_COMMIT: begin
          state_q        <= ST_IDLE;
          busy           <= 1'b0;
          last_served_24 <= pend_24;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_time_set_arbiter.sv
// Directed, table-driven bench for time_set_arbiter; timeout sequence runs when TIMEOUT_EN is defined.
module tb_time_set_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req12 = 1'b0, req24 = 1'b0, prop12 = 1'b0, prop24 = 1'b0, cancel = 1'b0;
  logic       in12_isPM = 1'b0;
  logic [3:0] in12_hours = '0;
  logic [5:0] in12_minutes = '0;
  logic [4:0] in24_hours = '0;
  logic [5:0] in24_minutes = '0;
  logic       grant12, grant24, commit, err, busy;
  logic [4:0] commit_hours;
  logic [5:0] commit_minutes;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  time_set_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req12(req12), .req24(req24),
    .prop12(prop12), .in12_isPM(in12_isPM), .in12_hours(in12_hours), .in12_minutes(in12_minutes),
    .prop24(prop24), .in24_hours(in24_hours), .in24_minutes(in24_minutes), .cancel(cancel),
    .grant12(grant12), .grant24(grant24), .commit(commit), .commit_hours(commit_hours),
    .commit_minutes(commit_minutes), .err(err), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is24;
    logic       pm;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic       exp_err;
    logic [4:0] exp_h;
    logic [5:0] exp_m;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, state, 0);
    check({tag, " grants"}, {grant12, grant24}, 0);
    check({tag, " commit"}, commit, 0);
    check({tag, " err"}, err, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " commit_time"}, {commit_hours, commit_minutes}, 0);
  endtask

  initial begin
    logic [4:0] last_h;
    logic [5:0] last_m;

    vecs[0]  = '{1'b0, 1'b0, 5'd12, 6'd0,  1'b0, 5'd0,  6'd0};
    vecs[1]  = '{1'b0, 1'b1, 5'd12, 6'd30, 1'b0, 5'd12, 6'd30};
    vecs[2]  = '{1'b1, 1'b0, 5'd23, 6'd59, 1'b0, 5'd23, 6'd59};
    vecs[3]  = '{1'b1, 1'b0, 5'd24, 6'd0,  1'b1, 5'd0,  6'd0};
    vecs[4]  = '{1'b0, 1'b0, 5'd11, 6'd45, 1'b0, 5'd11, 6'd45};
    vecs[5]  = '{1'b0, 1'b1, 5'd11, 6'd59, 1'b0, 5'd23, 6'd59};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  6'd10, 1'b1, 5'd0,  6'd0};
    vecs[7]  = '{1'b0, 1'b1, 5'd13, 6'd10, 1'b1, 5'd0,  6'd0};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  6'd0,  1'b0, 5'd0,  6'd0};
    vecs[9]  = '{1'b1, 1'b0, 5'd10, 6'd60, 1'b1, 5'd0,  6'd0};
    vecs[10] = '{1'b0, 1'b1, 5'd1,  6'd59, 1'b0, 5'd13, 6'd59};

    // Reset state, then first 12h transaction: 3:15 PM -> 15:15.
    #12;
    check_all_zero("in_reset");
    reset = 1'b1;
    step();
    check_all_zero("after_reset");
    req12 = 1'b1;
    step();
    req12 = 1'b0;
    check("first grant12", grant12, 1);
    check("first grant24", grant24, 0);
    check("first state", state, 1);
    check("first busy", busy, 1);
    prop12 = 1'b1; in12_isPM = 1'b1; in12_hours = 4'd3; in12_minutes = 6'd15;
    step();
    prop12 = 1'b0;
    check("first commit", commit, 1);
    check("first hours", commit_hours, 15);
    check("first minutes", commit_minutes, 15);
    check("first commit state", state, 3);
    check("first grant dropped", grant12, 0);
    step();
    check("first commit pulse end", commit, 0);
    check("first back idle", state, 0);
    check("first hold hours", commit_hours, 15);

    // Fresh reset: tie goes to 12h first, then round-robin to 24h.
    reset = 1'b0;
    #2;
    check_all_zero("reset2");
    reset = 1'b1;
    step();
    req12 = 1'b1; req24 = 1'b1;
    step();
    check("tie first grant12", grant12, 1);
    check("tie first grant24", grant24, 0);
    prop12 = 1'b1; in12_isPM = 1'b1; in12_hours = 4'd1; in12_minutes = 6'd0;
    step();
    prop12 = 1'b0;
    check("tie commit", commit, 1);
    check("tie hours", commit_hours, 13);
    step();
    check("tie idle", state, 0);
    step();
    check("tie second grant24", grant24, 1);
    check("tie second grant12", grant12, 0);
    req12 = 1'b0; req24 = 1'b0;
    step();
    check("req drop keeps grant24", grant24, 1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel state", state, 0);
    check("cancel grant24", grant24, 0);
    check("cancel no commit", commit, 0);
    check("cancel hold hours", commit_hours, 13);
    last_h = 5'd13;
    last_m = 6'd0;

    // Table of single-owner transactions.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is24) req24 = 1'b1; else req12 = 1'b1;
      step();
      req12 = 1'b0; req24 = 1'b0;
      check($sformatf("vec%0d grant", i), {grant12, grant24}, vecs[i].is24 ? 1 : 2);
      if (vecs[i].is24) begin
        prop24 = 1'b1; in24_hours = vecs[i].hours; in24_minutes = vecs[i].minutes;
      end else begin
        prop12 = 1'b1; in12_isPM = vecs[i].pm; in12_hours = vecs[i].hours[3:0];
        in12_minutes = vecs[i].minutes;
      end
      step();
      prop12 = 1'b0; prop24 = 1'b0;
      if (vecs[i].exp_err) begin
        check($sformatf("vec%0d err", i), err, 1);
        check($sformatf("vec%0d no commit", i), commit, 0);
        check($sformatf("vec%0d err state", i), state, 0);
        check($sformatf("vec%0d held time", i), {commit_hours, commit_minutes}, {last_h, last_m});
      end else begin
        check($sformatf("vec%0d commit", i), commit, 1);
        check($sformatf("vec%0d no err", i), err, 0);
        check($sformatf("vec%0d time", i), {commit_hours, commit_minutes}, {vecs[i].exp_h, vecs[i].exp_m});
        last_h = vecs[i].exp_h;
        last_m = vecs[i].exp_m;
      end
      step();
      check($sformatf("vec%0d pulses end", i), {commit, err}, 0);
      check($sformatf("vec%0d idle", i), state, 0);
    end

    // Foreign prop ignored; prop and cancel together -> commit.
    req12 = 1'b1;
    step();
    req12 = 1'b0;
    prop24 = 1'b1; in24_hours = 5'd5; in24_minutes = 6'd5;
    step();
    prop24 = 1'b0;
    check("foreign prop state", state, 1);
    check("foreign prop commit", commit, 0);
    check("foreign prop grant12", grant12, 1);
    prop12 = 1'b1; cancel = 1'b1; in12_isPM = 1'b0; in12_hours = 4'd7; in12_minutes = 6'd20;
    step();
    prop12 = 1'b0; cancel = 1'b0;
    check("prop wins commit", commit, 1);
    check("prop wins time", {commit_hours, commit_minutes}, {5'd7, 6'd20});
    step();

    // Reset mid-grant and in COMMIT clears everything immediately.
    req24 = 1'b1;
    step();
    req24 = 1'b0;
    check("pre-reset grant24", grant24, 1);
    reset = 1'b0;
    #2;
    check_all_zero("reset_mid_grant");
    reset = 1'b1;
    step();
    req12 = 1'b1;
    step();
    req12 = 1'b0;
    prop12 = 1'b1; in12_isPM = 1'b1; in12_hours = 4'd9; in12_minutes = 6'd1;
    step();
    prop12 = 1'b0;
    check("pre-reset commit", commit, 1);
    reset = 1'b0;
    #2;
    check_all_zero("reset_in_commit");
    reset = 1'b1;
    step();

`ifdef TIMEOUT_EN
    // Idle grant is revoked after 8 cycles; prop on the last cycle still wins.
    req12 = 1'b1;
    step();
    req12 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      check($sformatf("timeout hold %0d", c), grant12, 1);
    end
    step();
    check("timeout state", state, 0);
    check("timeout grant", grant12, 0);
    check("timeout no commit", commit, 0);
    step();
    req24 = 1'b1;
    step();
    req24 = 1'b0;
    for (int c = 0; c < 7; c++) step();
    prop24 = 1'b1; in24_hours = 5'd20; in24_minutes = 6'd40;
    step();
    prop24 = 1'b0;
    check("timeout prop wins", commit, 1);
    check("timeout prop time", {commit_hours, commit_minutes}, {5'd20, 6'd40});
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
